tt_pin_cmd_responder: RTL

- Responder end of the pin-level command protocol that the cocotb bench drives through a TinyTapeout user-project top.
- Host presents a command byte on ui_in and raises a request strobe on uio_in[0].
- Block decodes the byte, updates an 8x8 register file, drives a response byte on uo_out and completes a 4-phase req/ack handshake on uio_out[1].
- Instantiated directly under the tt_um_* top; top-level pins map 1:1.

---
 rtl/tt_pin_cmd_responder_pkg.sv | 23 ++
 rtl/tt_pin_cmd_responder_req_sync.sv | 27 ++
 rtl/tt_pin_cmd_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tt_pin_cmd_responder_pkg.sv
// tt_cmd_pkg: shared definitions for the pin-level command responder.
//   - opcode values carried in cmd[7:4]
//   - FSM state enum; its encoding is visible on uio_out[4:3]
//   - fixed response and pin-direction constants
package tt_cmd_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_INC   = 4'h3;
  localparam logic [3:0] OP_CSUM  = 4'hE;
  localparam logic [3:0] OP_ID    = 4'hF;

  localparam logic [7:0] ERR_RESP   = 8'hEE;
  localparam logic [7:0] UIO_OE_VAL = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/tt_pin_cmd_responder_req_sync.sv
// tt_req_sync: multi-flop synchronizer for the asynchronous host request.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (clears every stage)
//   d      in  asynchronous input
//   q      out synchronized output (SYNC_STAGES clock edges of latency)
module tt_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (!rst_n) stages <= '0;
    else        stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/tt_pin_cmd_responder.sv
// tt_pin_cmd_responder: responder end of the pin-level req/ack command
// protocol. A command byte on ui_in is accepted when the synchronized request
// rises, decoded against an 8x8 register file, and answered on uo_out with a
// 4-phase handshake.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   ena      in  design-selected enable (gates acceptance in IDLE only)
//   ui_in    in  command / operand byte
//   uio_in   in  bit0 = req; bits 7:1 ignored
//   uo_out   out response byte
//   uio_out  out bit1 = ack, bit2 = err, bits 4:3 = state code, others 0
//   uio_oe   out constant 8'hFE
// Build option: define TT_CMD_CHECKSUM_EN to add the running XOR checksum of
// every executed byte, readable with opcode 0xE. Without it 0xE is illegal.
module tt_pin_cmd_responder
  import tt_cmd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state, state_next;
  logic       req_s;
  logic       ack;
  logic       err;
  logic       pending;
  logic [2:0] addr_q;
  logic [7:0] cmd_q;
  logic [7:0] resp;
  logic [7:0] regs [8];

  logic [3:0] op;
  logic [2:0] a;
  logic [7:0] inc_val;

  logic unused_uio;
  assign unused_uio = ^uio_in[7:1];

  tt_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[0]),
    .q     (req_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    case (state)
      ST_IDLE: if (req_s && ena) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_ACK;
      ST_ACK: begin
        ack = 1'b1;
        if (!req_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // cmd[3] is deliberately not part of the decode.
  assign op      = cmd_q[7:4];
  assign a       = cmd_q[2:0];
  assign inc_val = regs[a] + 8'd1;

`ifdef TT_CMD_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_next;
  assign csum_next = csum ^ cmd_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                 csum <= 8'h00;
    else if (state == ST_EXEC)  csum <= csum_next;
  end
`endif

  // NOTE: the register file is reset explicitly; a read of a never-written
  // register must return 8'h00, so it cannot be left as an uninitialised RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q   <= 8'h00;
      resp    <= 8'h00;
      err     <= 1'b0;
      pending <= 1'b0;
      addr_q  <= 3'd0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      if (state == ST_IDLE && req_s && ena) cmd_q <= ui_in;

      if (state == ST_EXEC) begin
        err <= 1'b0;
        if (pending) begin
          // Operand byte of a WRITE: stored verbatim, never decoded.
          regs[addr_q] <= cmd_q;
          resp         <= cmd_q;
          pending      <= 1'b0;
        end else begin
          case (op)
            OP_NOP: ;
            OP_WRITE: begin
              pending <= 1'b1;
              addr_q  <= a;
            end
            OP_READ: resp <= regs[a];
            OP_INC: begin
              regs[a] <= inc_val;
              resp    <= inc_val;
            end
            OP_ID: resp <= ID_BYTE;
`ifdef TT_CMD_CHECKSUM_EN
            OP_CSUM: resp <= csum_next;
`endif
            default: begin
              resp <= ERR_RESP;
              err  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign uo_out  = resp;
  assign uio_out = {3'b000, state, err, ack, 1'b0};
  assign uio_oe  = UIO_OE_VAL;

endmodule
